// File: rtl/zuc_pkg.sv
// Shared definitions for the ZUC channel wrapper.
//   rel_state_t   : output release state (store-and-forward control)
//   STATUS_WIDTH  : width of core status bytes
//   STATS_*       : bit-field layout of the 32-bit statistics word
package zuc_pkg;

  typedef enum logic [1:0] {
    REL_IDLE = 2'd0,
    REL_PKT  = 2'd1,
    REL_OVF  = 2'd2
  } rel_state_t;

  localparam int STATUS_WIDTH  = 8;

  localparam int STATS_IN_W    = 16;  // [15:0]  packets in
  localparam int STATS_OUT_W   = 15;  // [30:16] packets out
  localparam int STATS_OVF_BIT = 31;  // sticky oversize flag

endpackage

// File: rtl/zuc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   wr_en/wr_data/full  : write side, writes ignored while full
//   rd_en/rd_data/empty : read side, rd_data valid whenever !empty
//   count               : occupancy, DEPTH+1 representable
// full, empty and count are registered; a word written into an empty FIFO
// is presented on rd_data the following cycle.
module zuc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             push;
  logic             pop;

  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/zuc_channel_wrapper.sv
// Buffering shell around one ZUC core channel.
//   zcw_in_*          : ID-selected ingress into the input FIFO
//   zcw_core_in_*     : input FIFO towards the core
//   zcw_core_out_*    : core results into the output FIFO
//   zcw_core_status_* : core status bytes into the status FIFO
//   zcw_out_* / zcw_status_* : ID-selected egress of data and status
//   zcw_in_watermark(_met)   : free input space threshold, 1-cycle latency
//   zcw_in_count / zcw_out_count : FIFO occupancies
//   zcw_stats         : {oversize flag, packets out, packets in}
// With STORE_FORWARD=1 egress is released only for complete packets; a packet
// that fills the output FIFO on its own falls back to cut-through.
module zuc_channel_wrapper
  import zuc_pkg::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int IN_DEPTH      = 512,
  parameter int OUT_DEPTH     = 512,
  parameter int STATUS_DEPTH  = 32,
  parameter int ID_WIDTH      = 3,
  parameter int STORE_FORWARD = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ID_WIDTH-1:0]         zcw_module_id,
  input  logic [ID_WIDTH-1:0]         zcw_in_id,
  input  logic                        zcw_in_valid,
  output logic                        zcw_in_ready,
  input  logic [DATA_WIDTH-1:0]       zcw_in_data,
  input  logic                        zcw_in_last,
  input  logic                        zcw_in_user,
  output logic                        zcw_core_in_valid,
  input  logic                        zcw_core_in_ready,
  output logic [DATA_WIDTH-1:0]       zcw_core_in_data,
  output logic                        zcw_core_in_last,
  output logic                        zcw_core_in_user,
  input  logic                        zcw_core_out_valid,
  output logic                        zcw_core_out_ready,
  input  logic [DATA_WIDTH-1:0]       zcw_core_out_data,
  input  logic                        zcw_core_out_last,
  input  logic                        zcw_core_out_user,
  input  logic                        zcw_core_status_valid,
  output logic                        zcw_core_status_ready,
  input  logic [STATUS_WIDTH-1:0]     zcw_core_status_data,
  input  logic [ID_WIDTH-1:0]         zcw_out_id,
  input  logic                        zcw_out_ready,
  input  logic                        zcw_status_ready,
  output logic                        zcw_out_valid,
  output logic [DATA_WIDTH-1:0]       zcw_out_data,
  output logic                        zcw_out_last,
  output logic                        zcw_out_user,
  output logic                        zcw_status_valid,
  output logic [STATUS_WIDTH-1:0]     zcw_status_data,
  input  logic [$clog2(IN_DEPTH):0]   zcw_in_watermark,
  output logic                        zcw_in_watermark_met,
  output logic [$clog2(IN_DEPTH):0]   zcw_in_count,
  output logic [$clog2(OUT_DEPTH):0]  zcw_out_count,
  output logic [31:0]                 zcw_stats
);

  localparam int IW = $clog2(IN_DEPTH) + 1;
  localparam int OW = $clog2(OUT_DEPTH) + 1;
  localparam int SW = $clog2(STATUS_DEPTH) + 1;
  localparam int PW = DATA_WIDTH + 2;

  logic                   in_full, in_empty, out_full, out_empty, st_full, st_empty;
  logic [PW-1:0]          in_rd, out_rd;
  logic [SW-1:0]          st_count_unused;  // status occupancy is not exported
  logic                   ready_en;
  logic                   in_push, out_push, out_sel, out_pop, out_pop_last;
  logic [IW-1:0]          in_free;
  rel_state_t             rel_state, rel_next;
  logic                   enter_ovf, out_release, ovf_last_seen;
  logic                   pkt_inc, pkt_dec;
  logic [OW-1:0]          pkt_cnt;
  logic [STATS_IN_W-1:0]  pkts_in;
  logic [STATS_OUT_W-1:0] pkts_out;
  logic                   ovf_flag;

  // Ready is held low through reset and only follows !full afterwards.
  assign zcw_in_ready = ready_en & ~in_full;
  assign in_push      = zcw_in_valid & (zcw_in_id == zcw_module_id) & zcw_in_ready;

  zuc_sync_fifo #(.WIDTH(PW), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset),
    .wr_en(in_push), .wr_data({zcw_in_user, zcw_in_last, zcw_in_data}), .full(in_full),
    .rd_en(zcw_core_in_ready), .rd_data(in_rd), .empty(in_empty), .count(zcw_in_count)
  );

  assign zcw_core_in_valid = ~in_empty;
  assign {zcw_core_in_user, zcw_core_in_last, zcw_core_in_data} = in_rd;

  assign zcw_core_out_ready = ~out_full;
  assign out_push           = zcw_core_out_valid & ~out_full;
  assign out_sel            = (zcw_out_id == zcw_module_id);
  assign out_pop            = out_sel & zcw_out_ready & zcw_out_valid;
  assign out_pop_last       = out_pop & zcw_out_last;

  zuc_sync_fifo #(.WIDTH(PW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .reset(reset),
    .wr_en(zcw_core_out_valid), .wr_data({zcw_core_out_user, zcw_core_out_last, zcw_core_out_data}),
    .full(out_full),
    .rd_en(out_pop), .rd_data(out_rd), .empty(out_empty), .count(zcw_out_count)
  );

  assign {zcw_out_user, zcw_out_last, zcw_out_data} = out_rd;

  zuc_sync_fifo #(.WIDTH(STATUS_WIDTH), .DEPTH(STATUS_DEPTH)) u_status_fifo (
    .clk(clk), .reset(reset),
    .wr_en(zcw_core_status_valid), .wr_data(zcw_core_status_data), .full(st_full),
    .rd_en(zcw_status_ready & out_sel), .rd_data(zcw_status_data), .empty(st_empty),
    .count(st_count_unused)
  );

  assign zcw_core_status_ready = ~st_full;
  assign zcw_status_valid      = ~st_empty;

  // The first last written after entering REL_OVF closes the oversize packet
  // and is not counted; its pop ends REL_OVF without touching pkt_cnt.
  assign pkt_inc = (STORE_FORWARD != 0) & out_push & zcw_core_out_last &
                   ((rel_state != REL_OVF) | ovf_last_seen);
  assign pkt_dec = (STORE_FORWARD != 0) & out_pop_last & (rel_state != REL_OVF);

  always_ff @(posedge clk) begin
    if (reset) rel_state <= REL_IDLE;
    else       rel_state <= rel_next;
  end

  always_comb begin
    rel_next  = rel_state;
    enter_ovf = 1'b0;
    if (STORE_FORWARD != 0) begin
      unique case (rel_state)
        REL_IDLE: begin
          if (pkt_cnt != '0) begin
            rel_next = REL_PKT;
          end else if (out_full) begin
            rel_next  = REL_OVF;
            enter_ovf = 1'b1;
          end
        end
        REL_PKT:  if (out_pop_last && !pkt_inc && pkt_cnt == OW'(1)) rel_next = REL_IDLE;
        REL_OVF:  if (out_pop_last) rel_next = REL_IDLE;
        default:  rel_next = REL_IDLE;
      endcase
    end
  end

  always_comb begin
    out_release = 1'b0;
    unique case (rel_state)
      REL_PKT, REL_OVF: out_release = 1'b1;
      default:          out_release = 1'b0;
    endcase
  end

  assign zcw_out_valid = (STORE_FORWARD != 0) ? (out_release & ~out_empty) : ~out_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt       <= '0;
      ovf_last_seen <= 1'b0;
    end else begin
      if (pkt_inc && !pkt_dec)      pkt_cnt <= pkt_cnt + 1'b1;
      else if (pkt_dec && !pkt_inc) pkt_cnt <= pkt_cnt - 1'b1;
      if (enter_ovf)
        ovf_last_seen <= 1'b0;
      else if (rel_state == REL_OVF && out_push && zcw_core_out_last)
        ovf_last_seen <= 1'b1;
    end
  end

  assign in_free = IW'(IN_DEPTH) - zcw_in_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en             <= 1'b0;
      zcw_in_watermark_met <= 1'b0;
      pkts_in              <= '0;
      pkts_out             <= '0;
      ovf_flag             <= 1'b0;
    end else begin
      ready_en             <= 1'b1;
      zcw_in_watermark_met <= (in_free >= zcw_in_watermark);
      if (in_push && zcw_in_last && !(&pkts_in)) pkts_in  <= pkts_in + 1'b1;
      if (out_pop_last && !(&pkts_out))          pkts_out <= pkts_out + 1'b1;
      if (enter_ovf)                             ovf_flag <= 1'b1;
    end
  end

  assign zcw_stats = {ovf_flag, pkts_out, pkts_in};

endmodule

// File: tb/tb_zuc_channel_wrapper.sv
module tb_zuc_channel_wrapper;
  import zuc_pkg::*;

  localparam int DW   = 32;
  localparam int IND  = 16;
  localparam int OUTD = 8;
  localparam int STD  = 4;
  localparam int IDW  = 3;
  localparam logic [IDW-1:0] MY_ID = 3'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [IDW-1:0] zcw_module_id, zcw_in_id, zcw_out_id;
  logic zcw_in_valid, zcw_in_ready, zcw_in_last, zcw_in_user;
  logic [DW-1:0] zcw_in_data;
  logic zcw_core_in_valid, zcw_core_in_ready, zcw_core_in_last, zcw_core_in_user;
  logic [DW-1:0] zcw_core_in_data;
  logic zcw_core_out_valid, zcw_core_out_ready, zcw_core_out_last, zcw_core_out_user;
  logic [DW-1:0] zcw_core_out_data;
  logic zcw_core_status_valid, zcw_core_status_ready;
  logic [7:0] zcw_core_status_data;
  logic zcw_out_ready, zcw_status_ready, zcw_out_valid, zcw_out_last, zcw_out_user;
  logic [DW-1:0] zcw_out_data;
  logic zcw_status_valid;
  logic [7:0] zcw_status_data;
  logic [$clog2(IND):0] zcw_in_watermark, zcw_in_count;
  logic zcw_in_watermark_met;
  logic [$clog2(OUTD):0] zcw_out_count;
  logic [31:0] zcw_stats;

  zuc_channel_wrapper #(
    .DATA_WIDTH(DW), .IN_DEPTH(IND), .OUT_DEPTH(OUTD), .STATUS_DEPTH(STD),
    .ID_WIDTH(IDW), .STORE_FORWARD(1)
  ) dut (
    .clk(clk), .reset(reset), .zcw_module_id(zcw_module_id),
    .zcw_in_id(zcw_in_id), .zcw_in_valid(zcw_in_valid), .zcw_in_ready(zcw_in_ready),
    .zcw_in_data(zcw_in_data), .zcw_in_last(zcw_in_last), .zcw_in_user(zcw_in_user),
    .zcw_core_in_valid(zcw_core_in_valid), .zcw_core_in_ready(zcw_core_in_ready),
    .zcw_core_in_data(zcw_core_in_data), .zcw_core_in_last(zcw_core_in_last),
    .zcw_core_in_user(zcw_core_in_user),
    .zcw_core_out_valid(zcw_core_out_valid), .zcw_core_out_ready(zcw_core_out_ready),
    .zcw_core_out_data(zcw_core_out_data), .zcw_core_out_last(zcw_core_out_last),
    .zcw_core_out_user(zcw_core_out_user),
    .zcw_core_status_valid(zcw_core_status_valid), .zcw_core_status_ready(zcw_core_status_ready),
    .zcw_core_status_data(zcw_core_status_data),
    .zcw_out_id(zcw_out_id), .zcw_out_ready(zcw_out_ready), .zcw_status_ready(zcw_status_ready),
    .zcw_out_valid(zcw_out_valid), .zcw_out_data(zcw_out_data), .zcw_out_last(zcw_out_last),
    .zcw_out_user(zcw_out_user), .zcw_status_valid(zcw_status_valid),
    .zcw_status_data(zcw_status_data), .zcw_in_watermark(zcw_in_watermark),
    .zcw_in_watermark_met(zcw_in_watermark_met), .zcw_in_count(zcw_in_count),
    .zcw_out_count(zcw_out_count), .zcw_stats(zcw_stats)
  );

  typedef struct packed {
    logic          user;
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  // Reference model: queues of buffered words plus packet-level bookkeeping.
  word_t      in_q[$];
  word_t      out_q[$];
  logic [7:0] st_q[$];
  int         complete;     // complete packets waiting in the output queue
  bit         ovf;          // oversize packet being cut through
  bit         ovf_open;     // oversize packet's last not yet written
  bit         sticky;
  bit         exp_ready, exp_met, checking, last_out_push;
  int         pin, pout;
  int unsigned checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit ip, ipop, op, opop, eo, sp, spop, rst;
    int sz_in;
    word_t w;
    @(negedge clk);
    if (checking) begin
      chk("in_ready", zcw_in_ready, exp_ready);
      chk("in_count", zcw_in_count, in_q.size());
      chk("core_in_valid", zcw_core_in_valid, in_q.size() > 0);
      if (in_q.size() > 0)
        chk("core_in_word", {zcw_core_in_user, zcw_core_in_last, zcw_core_in_data}, in_q[0]);
      chk("out_count", zcw_out_count, out_q.size());
      chk("core_out_ready", zcw_core_out_ready, out_q.size() < OUTD);
      if (out_q.size() == 0) chk("out_valid_empty", zcw_out_valid, 0);
      else if (ovf) chk("out_valid_ovf", zcw_out_valid, 1);
      else if (complete == 0) chk("out_valid_hold", zcw_out_valid, 0);
      if (zcw_out_valid && out_q.size() > 0)
        chk("out_word", {zcw_out_user, zcw_out_last, zcw_out_data}, out_q[0]);
      chk("status_valid", zcw_status_valid, st_q.size() > 0);
      if (st_q.size() > 0) chk("status_data", zcw_status_data, st_q[0]);
      chk("wm_met", zcw_in_watermark_met, exp_met);
      chk("stats", zcw_stats, {sticky, 15'(pout), 16'(pin)});
    end
    rst   = reset;
    sz_in = in_q.size();
    ip    = zcw_in_valid && zcw_in_id == MY_ID && exp_ready;
    ipop  = zcw_core_in_ready && sz_in > 0;
    op    = zcw_core_out_valid && out_q.size() < OUTD;
    opop  = zcw_out_valid && zcw_out_ready && zcw_out_id == MY_ID && out_q.size() > 0;
    eo    = out_q.size() == OUTD && complete == 0 && !ovf;
    sp    = zcw_core_status_valid && st_q.size() < STD;
    spop  = zcw_status_ready && zcw_out_id == MY_ID && st_q.size() > 0;
    w     = '{user: zcw_in_user, last: zcw_in_last, data: zcw_in_data};
    last_out_push = 1'b0;
    @(posedge clk);
    #1;
    if (rst) begin
      in_q.delete(); out_q.delete(); st_q.delete();
      complete = 0; ovf = 0; ovf_open = 0; sticky = 0;
      pin = 0; pout = 0; exp_ready = 0; exp_met = 0;
    end else begin
      exp_met = (IND - sz_in) >= int'(zcw_in_watermark);
      if (ipop) void'(in_q.pop_front());
      if (ip) begin
        in_q.push_back(w);
        if (w.last && pin < 65535) pin++;
      end
      exp_ready = in_q.size() < IND;
      if (opop) begin
        word_t o;
        o = out_q.pop_front();
        if (o.last) begin
          if (pout < 32767) pout++;
          if (ovf) ovf = 0;
          else     complete--;
        end
      end
      if (op) begin
        last_out_push = 1'b1;
        out_q.push_back('{user: zcw_core_out_user, last: zcw_core_out_last, data: zcw_core_out_data});
        if (zcw_core_out_last) begin
          if (ovf_open) ovf_open = 0;
          else          complete++;
        end
      end
      if (eo) begin ovf = 1; ovf_open = 1; sticky = 1; end
      if (spop) void'(st_q.pop_front());
      if (sp) st_q.push_back(zcw_core_status_data);
    end
  endtask

  initial begin
    int guard;
    int cur_len;
    reset = 1; zcw_module_id = MY_ID; zcw_in_id = MY_ID; zcw_out_id = MY_ID;
    zcw_in_valid = 0; zcw_in_data = '0; zcw_in_last = 0; zcw_in_user = 0;
    zcw_core_in_ready = 0; zcw_core_out_valid = 0; zcw_core_out_data = '0;
    zcw_core_out_last = 0; zcw_core_out_user = 0; zcw_core_status_valid = 0;
    zcw_core_status_data = '0; zcw_out_ready = 0; zcw_status_ready = 0;
    zcw_in_watermark = '0; checking = 0;

    // Reset state
    tick();
    checking = 1;
    tick();
    chk("rst_in_ready", zcw_in_ready, 0);
    chk("rst_counts", {zcw_in_count, zcw_out_count}, 0);
    reset = 0;
    tick();
    chk("post_rst_ready", zcw_in_ready, 1);

    // ID gating
    zcw_in_valid = 1;
    for (int i = 0; i < 4; i++) begin zcw_in_id = 3'd2; zcw_in_data = 32'hA000_0000 + i; tick(); end
    chk("id_gate_reject", zcw_in_count, 0);
    for (int i = 0; i < 4; i++) begin
      zcw_in_id = MY_ID; zcw_in_data = $urandom; zcw_in_user = 1'($urandom); zcw_in_last = (i == 3);
      tick();
      if (i == 0) chk("core_in_n_plus_1", zcw_core_in_valid, 1);
    end
    zcw_in_valid = 0; zcw_in_last = 0;
    chk("id_gate_count", zcw_in_count, 4);

    // Watermark
    zcw_in_watermark = 10; zcw_in_valid = 1;
    repeat (2) begin zcw_in_data = $urandom; tick(); end
    zcw_in_valid = 0; tick();
    chk("wm_fill6", zcw_in_watermark_met, 1);
    zcw_in_valid = 1; zcw_in_data = $urandom; tick(); zcw_in_valid = 0;
    chk("wm_latency", zcw_in_watermark_met, 1);
    tick();
    chk("wm_fill7", zcw_in_watermark_met, 0);

    // Full / back-pressure
    zcw_in_valid = 1;
    repeat (11) begin zcw_in_data = $urandom; tick(); end
    zcw_in_valid = 0;
    chk("full_count", zcw_in_count, IND);
    chk("full_ready", zcw_in_ready, 0);
    zcw_core_in_ready = 1;
    repeat (12) tick();
    zcw_in_valid = 1; zcw_in_data = $urandom; tick(); zcw_in_valid = 0;
    chk("simul_count", zcw_in_count, 4);
    guard = 0;
    while (in_q.size() > 0 && guard < 40) begin tick(); guard++; end
    chk("in_drained", zcw_in_count, 0);
    zcw_core_in_ready = 0;

    // Store-and-forward, 3-word packet
    zcw_out_ready = 1; zcw_core_out_valid = 1;
    for (int i = 0; i < 3; i++) begin
      zcw_core_out_data = 32'hB000_0000 + i; zcw_core_out_last = (i == 2); tick();
      if (i < 2) chk("sf_hold", zcw_out_valid, 0);
    end
    zcw_core_out_valid = 0; zcw_core_out_last = 0;
    tick();
    chk("sf_release", zcw_out_valid, 1);
    guard = 0;
    while (out_q.size() > 0 && guard < 20) begin tick(); guard++; end
    chk("sf_drained", zcw_out_count, 0);
    chk("sf_pkts_out", zcw_stats[30:16], 1);

    // Oversize packet with egress stalled
    zcw_out_ready = 0; zcw_core_out_valid = 1;
    for (int i = 0; i < 8; i++) begin zcw_core_out_data = 32'hC0DE_0000 + i; tick(); end
    zcw_core_out_data = 32'hC0DE_0008; tick();
    chk("ovf_flag", zcw_stats[31], 1);
    chk("ovf_out_valid", zcw_out_valid, 1);
    zcw_out_ready = 1;
    for (int i = 8; i < 12; i++) begin
      zcw_core_out_data = 32'hC0DE_0000 + i; zcw_core_out_last = (i == 11);
      guard = 0;
      do begin tick(); guard++; end while (!last_out_push && guard < 20);
      chk("ovf_word_accept", last_out_push, 1);
    end
    zcw_core_out_valid = 0; zcw_core_out_last = 0;
    guard = 0;
    while (out_q.size() > 0 && guard < 40) begin tick(); guard++; end
    chk("ovf_drained", zcw_out_count, 0);
    chk("ovf_rel_idle", dut.rel_state, REL_IDLE);

    // Status path with ID gating on egress
    zcw_core_status_valid = 1;
    for (int i = 0; i < 2; i++) begin zcw_core_status_data = 8'h50 + 8'(i); tick(); end
    zcw_core_status_valid = 0; zcw_status_ready = 1; zcw_out_id = 3'd5;
    repeat (2) tick();
    chk("status_id_hold", zcw_status_valid, 1);
    zcw_out_id = MY_ID;
    repeat (2) tick();
    chk("status_drained", zcw_status_valid, 0);

    // Randomized traffic, packets of at most 4 words on the core side
    cur_len = 0;
    repeat (400) begin
      zcw_in_valid = 1'($urandom); zcw_in_id = 3'($urandom_range(2, 3));
      zcw_in_data = $urandom; zcw_in_last = ($urandom % 4) == 0; zcw_in_user = 1'($urandom);
      zcw_core_in_ready = 1'($urandom);
      zcw_core_out_valid = 1'($urandom); zcw_core_out_data = $urandom;
      zcw_core_out_user = 1'($urandom);
      zcw_core_out_last = (cur_len >= 3) || (($urandom % 4) == 0);
      zcw_core_status_valid = 1'($urandom); zcw_core_status_data = 8'($urandom);
      zcw_out_id = ($urandom % 3 == 0) ? 3'd6 : MY_ID;
      zcw_out_ready = 1'($urandom); zcw_status_ready = 1'($urandom);
      zcw_in_watermark = 5'($urandom_range(0, IND));
      tick();
      if (last_out_push) cur_len = zcw_core_out_last ? 0 : cur_len + 1;
    end
    // Finish the open packet so every word can be released
    zcw_in_valid = 0; zcw_core_status_valid = 0; zcw_out_id = MY_ID;
    zcw_core_out_valid = (cur_len != 0); zcw_core_out_last = 1;
    zcw_core_in_ready = 1; zcw_out_ready = 1; zcw_status_ready = 1;
    guard = 0;
    while (zcw_core_out_valid && guard < 40) begin
      tick(); guard++;
      if (last_out_push) zcw_core_out_valid = 0;
    end
    zcw_core_out_valid = 0; zcw_core_out_last = 0;
    guard = 0;
    while ((in_q.size() + out_q.size() + st_q.size()) > 0 && guard < 100) begin tick(); guard++; end
    chk("rand_drained", {zcw_in_count, zcw_out_count, zcw_status_valid}, 0);

    // Reset with data buffered mid-packet
    zcw_core_in_ready = 0; zcw_out_ready = 0; zcw_in_valid = 1; zcw_in_id = MY_ID; zcw_in_last = 0;
    repeat (5) begin zcw_in_data = $urandom; tick(); end
    zcw_in_valid = 0;
    zcw_core_out_valid = 1;
    repeat (2) begin zcw_core_out_data = $urandom; tick(); end
    zcw_core_out_valid = 0;
    chk("pre_rst_count", zcw_in_count, 5);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_counts", {zcw_in_count, zcw_out_count}, 0);
    chk("mid_rst_out_valid", zcw_out_valid, 0);
    chk("mid_rst_stats", zcw_stats, 0);
    chk("mid_rst_ready_low", zcw_in_ready, 0);
    tick();
    chk("mid_rst_ready", zcw_in_ready, 1);
    zcw_out_ready = 1;
    repeat (4) tick();
    chk("mid_rst_no_out", zcw_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
